// File: rtl/pmem_responder.sv
// Line-granular 128-bit physical-memory responder: one request at a time,
// programmable latency, single-cycle completion pulse, sticky protocol-error flag.
module pmem_responder #(
  parameter int unsigned LINES   = 256,
  parameter int unsigned LATENCY = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic         pmem_resp,
  output logic [127:0] pmem_rdata,
  output logic         proto_err
);

  localparam int unsigned LINE_W = 128;
  localparam int unsigned AHI_W  = 12;
  localparam int unsigned IDX_W  = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int unsigned CNT_W  = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                op_wr;
  logic [AHI_W-1:0]    addr_hi;
  logic [LINE_W-1:0]   wdata_q;
  logic [LINE_W-1:0]   mem [LINES];
  logic [LINES-1:0]    valid;

  logic                req_c;
  logic                done_c;
  logic                commit_c;
  logic                viol_c;
  logic [IDX_W-1:0]    idx_c;
  logic                unused_addr_lsb;

  assign req_c    = pmem_read | pmem_write;
  assign done_c   = (state == ST_BUSY) && req_c && (cnt == '0);
  assign commit_c = done_c && op_wr;
  assign idx_c    = addr_hi[IDX_W-1:0];
  assign unused_addr_lsb = ^pmem_address[3:0];

  // Initiator must hold address, write data and direction stable while busy.
  assign viol_c = (pmem_address[15:4] != addr_hi)
                | (op_wr && (pmem_wdata != wdata_q))
                | (op_wr ? pmem_read : pmem_write);

  // Line storage carries no reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (commit_c) begin
      mem[idx_c] <= wdata_q;
    end
  end

  // Transaction FSM with registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      op_wr      <= 1'b0;
      addr_hi    <= '0;
      wdata_q    <= '0;
      valid      <= '0;
      pmem_resp  <= 1'b0;
      pmem_rdata <= '0;
      proto_err  <= 1'b0;
    end else begin
      pmem_resp <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (req_c) begin
            state   <= ST_BUSY;
            op_wr   <= pmem_write;
            addr_hi <= pmem_address[15:4];
            wdata_q <= pmem_wdata;
            cnt     <= CNT_W'(LATENCY - 1);
            if (pmem_read && pmem_write) begin
              proto_err <= 1'b1;
            end
          end
        end
        ST_BUSY: begin
          if (!req_c) begin
            // Abort: request withdrawn before completion.
            state     <= ST_IDLE;
            proto_err <= 1'b1;
          end else begin
            if (viol_c) begin
              proto_err <= 1'b1;
            end
            if (cnt == '0) begin
              state     <= ST_RESP;
              pmem_resp <= 1'b1;
              if (op_wr) begin
                valid[idx_c] <= 1'b1;
              end else begin
                pmem_rdata <= valid[idx_c] ? mem[idx_c] : '0;
              end
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_responder.sv
// Self-checking bench for pmem_responder: directed test-plan cases plus random
// traffic checked against a line-array reference model.
module tb_pmem_responder;

  localparam int unsigned LINES   = 256;
  localparam int unsigned LATENCY = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         pmem_read = 1'b0;
  logic         pmem_write = 1'b0;
  logic [15:0]  pmem_address = '0;
  logic [127:0] pmem_wdata = '0;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;
  logic         proto_err;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  logic [127:0] ref_mem [LINES];
  bit           ref_valid [LINES];
  logic [127:0] ref_rdata = '0;
  bit           ref_perr = 1'b0;

  pmem_responder #(.LINES(LINES), .LATENCY(LATENCY)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata),
    .proto_err    (proto_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int line_of(input logic [15:0] a);
    return int'((32'(a) >> 4) % LINES);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
    ref_rdata = '0;
    ref_perr  = 1'b0;
  endfunction

  // mode: 0 normal, 1 hold request past the response, 2 read+write both high,
  // 3 address changes while busy.
  task automatic do_txn(input bit wr, input logic [15:0] addr, input logic [127:0] data,
                        input int mode);
    int    t0;
    int    rc;
    int    idx;
    int    extra;
    bit    seen;
    string dtag;
    idx = line_of(addr);
    if (mode == 2) begin
      wr = 1'b1;
      ref_perr = 1'b1;
    end
    @(negedge clk);
    chk("idle_resp_low", 128'(pmem_resp), 128'd0);
    pmem_write   = wr;
    pmem_read    = !wr || (mode == 2);
    pmem_address = addr;
    pmem_wdata   = data;
    t0 = cyc + 1;
    seen = 1'b0;
    rc = 0;
    for (int i = 0; i < int'(LATENCY) + 8 && !seen; i++) begin
      @(negedge clk);
      if (mode == 3 && i == 0) begin
        pmem_address = addr ^ 16'h0100;
        ref_perr = 1'b1;
      end
      if (pmem_resp) begin
        seen = 1'b1;
        rc = cyc;
      end
    end
    chk("resp_seen", 128'(seen), 128'd1);
    chk("latency", 128'(rc - t0), 128'(LATENCY));
    if (wr) begin
      ref_mem[idx]   = data;
      ref_valid[idx] = 1'b1;
    end else begin
      ref_rdata = ref_valid[idx] ? ref_mem[idx] : '0;
    end
    dtag = wr ? "rdata_hold" : "rdata";
    chk(dtag, pmem_rdata, ref_rdata);
    chk("proto_err", 128'(proto_err), 128'(ref_perr));
    if (mode == 1) begin
      @(negedge clk);
      chk("pulse_width", 128'(pmem_resp), 128'd0);
    end
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    if (mode == 1) begin
      extra = 0;
      repeat (LATENCY + 3) begin
        @(negedge clk);
        if (pmem_resp) extra++;
      end
      chk("no_retrigger", 128'(extra), 128'd0);
    end
  endtask

  task automatic do_abort(input logic [15:0] addr, input logic [127:0] data, input int drop_at);
    int nresp;
    nresp = 0;
    @(negedge clk);
    pmem_write   = 1'b1;
    pmem_address = addr;
    pmem_wdata   = data;
    repeat (drop_at) @(negedge clk);
    pmem_write = 1'b0;
    repeat (LATENCY + 4) begin
      @(negedge clk);
      if (pmem_resp) nresp++;
    end
    ref_perr = 1'b1;
    chk("abort_no_resp", 128'(nresp), 128'd0);
    chk("abort_perr", 128'(proto_err), 128'(ref_perr));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
    chk("rst_resp", 128'(pmem_resp), 128'd0);
    chk("rst_rdata", pmem_rdata, 128'd0);
    chk("rst_perr", 128'(proto_err), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0]  a;
    logic [127:0] d;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    chk("init_resp", 128'(pmem_resp), 128'd0);
    chk("init_rdata", pmem_rdata, 128'd0);
    chk("init_perr", 128'(proto_err), 128'd0);

    do_txn(1'b0, 16'h1230, '0, 0);
    do_txn(1'b1, 16'h0040, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 0);
    do_txn(1'b0, 16'h004C, '0, 0);
    do_txn(1'b1, 16'h0010, 128'h11112222_33334444_55556666_77778888, 0);
    do_txn(1'b0, 16'h1010, '0, 0);
    do_txn(1'b0, 16'h0020, '0, 0);
    do_txn(1'b0, 16'h0040, '0, 1);

    for (int k = 0; k < 40; k++) begin
      a = {4'($urandom), 8'($urandom_range(0, 7)), 4'($urandom)};
      d = {$urandom, $urandom, $urandom, $urandom};
      do_txn(1'($urandom_range(0, 1)), a, d, (k % 8 == 3) ? 1 : 0);
    end

    // Abort a write to a known line; old contents must survive.
    do_txn(1'b1, 16'h0070, 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0, 0);
    do_abort(16'h0070, 128'h0BAD0BAD_0BAD0BAD_0BAD0BAD_0BAD0BAD, 2);
    do_txn(1'b0, 16'h0070, '0, 0);
    do_txn(1'b0, 16'h0010, '0, 0);

    // Reset in the middle of a pending write.
    @(negedge clk);
    pmem_write   = 1'b1;
    pmem_address = 16'h0070;
    pmem_wdata   = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
    repeat (2) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_resp", 128'(pmem_resp), 128'd0);
    chk("mid_rst_rdata", pmem_rdata, 128'd0);
    chk("mid_rst_perr", 128'(proto_err), 128'd0);
    model_clear();
    pmem_write = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    do_txn(1'b0, 16'h0070, '0, 0);
    do_txn(1'b0, 16'h0040, '0, 0);

    // Protocol violations that still complete.
    do_txn(1'b0, 16'h0050, 128'h55555555_66666666_77777777_88888888, 2);
    do_txn(1'b0, 16'h0050, '0, 0);
    do_reset();
    do_txn(1'b1, 16'h0060, 128'h99990000_AAAA1111_BBBB2222_CCCC3333, 3);
    do_txn(1'b0, 16'h0060, '0, 0);
    do_txn(1'b0, 16'h0160, '0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pmem_responder.md
# pmem_responder

Line-granular physical-memory responder for the 128-bit `pmem_*` bus. The memory arbiter drives this bus as initiator. This block is the other end: it accepts one read or write request at a time, waits a programmable number of cycles, commits or returns a 16-byte line, and pulses `pmem_resp`. It stands in for main memory behind the arbiter and sits on the bench top alongside the CPU.

## Interface
- `LINES`, default 256: number of 128-bit lines stored; power of two, 2..4096.
- `LATENCY`, default 4: busy cycles between request acceptance and `pmem_resp`; must be ≥1.
- `clk` in 1: single clock, all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `pmem_read` in 1: read request; held high until `pmem_resp` is seen.
- `pmem_write` in 1: write request; held high until `pmem_resp` is seen.
- `pmem_address` in 16: byte address; held stable while the request is high.
- `pmem_wdata` in 128: write line; held stable while `pmem_write` is high.
- `pmem_resp` out 1: one-cycle completion pulse.
- `pmem_rdata` out 128: read line; valid while `pmem_resp` is high after a read.
- `proto_err` out 1: sticky flag for initiator protocol violations.

## Operation
- Line index is `pmem_address[4 +: log2(LINES)]`.
  - `pmem_address[3:0]` is ignored.
  - Address bits above the index alias onto the same lines.
- Storage: `LINES` × 128-bit array plus one valid bit per line.
  - Valid bits clear on reset; the array itself is not reset.
  - A read of an invalid line returns 128'h0.
  - A write sets the line's valid bit.
- FSM states: IDLE, BUSY, RESP.
  - IDLE → BUSY when `pmem_read | pmem_write` is high at an edge. On that edge, latch:
    - op: write if `pmem_write`, else read;
    - index;
    - `pmem_wdata`;
    - load the counter with `LATENCY-1`.
  - BUSY with counter ≠ 0 → BUSY; counter decrements by 1.
  - BUSY with counter = 0 → RESP. On this edge:
    - a write commits the latched data to the latched index;
    - a read loads `pmem_rdata` from the latched index.
  - RESP → IDLE unconditionally.
    - A request still high at the edge that ends RESP is the finished transaction and is not re-accepted.
    - IDLE samples for a new request at the following edge.
  - BUSY → IDLE at any edge where both `pmem_read` and `pmem_write` are low (abort). On an abort:
    - no commit, no response;
    - `proto_err` is set.
- Further `proto_err` set conditions (no other effect on the transaction):
  - `pmem_read` and `pmem_write` both high at acceptance; the transaction is treated as a write.
  - During BUSY, `pmem_address[15:4]` or `pmem_wdata` (writes only) differs from the latched value. The latched values are used.
  - The request changes from read to write, or write to read, during BUSY.
- `proto_err` clears only on reset.
- `pmem_rdata` holds its last read value through later writes and idle cycles.

## Timing
- Reset values:
  - state IDLE;
  - `pmem_resp` = 0;
  - `pmem_rdata` = 128'h0;
  - `proto_err` = 0;
  - counter = 0;
  - all valid bits = 0.
- Reset takes effect immediately, independent of `clk`.
- Reset during BUSY drops the transaction: no commit, no response.
- Acceptance at edge T gives `pmem_resp` high from edge T+`LATENCY` to edge T+`LATENCY`+1. `pmem_resp` is a registered output, driven from state RESP.
- Minimum request-to-request spacing:
  - The initiator drops its request at the edge ending RESP.
  - The earliest next acceptance is one edge later.
  - Throughput is one transaction per `LATENCY`+2 cycles.
- Read-after-write to the same line returns the new data; the commit precedes any later acceptance.
- All outputs are registered. No combinational path exists from inputs to outputs.

## Test plan
- Reset, then read address 0x1230 with `LATENCY`=4 → `pmem_resp` pulses exactly one cycle at T+4; `pmem_rdata`=0; `proto_err`=0.
- Write 128'hDEADBEEF_… to 0x0040, then read 0x004C → the read returns the written line (low nibble ignored); each response is a single-cycle pulse; the second acceptance is no earlier than T1+6.
- With `LINES`=256, write to 0x0010 and read 0x1010 → aliasing returns the same line; a read of untouched line 0x0020 returns 0.
- Hold `pmem_read` high one extra cycle after `pmem_resp` → exactly one response; no second transaction starts.
- Drop `pmem_write` at T+2 with `LATENCY`=4 → no `pmem_resp`; line not written (a later read returns the old value); `proto_err`=1 and sticky until reset.
- Assert `reset_n`=0 mid-BUSY → outputs return to reset values immediately; a later read of the pending write's line returns 0.
